// File: rtl/simd_addsat_pipe.sv
// simd_addsat_pipe: two-stage saturating SIMD adder (ADD/SUB/PADDS/RED) with valid/ready handshake
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake; a, b, mode sampled on transfer
//   out_valid/out_ready output handshake; sum, cout, ovfl held while stalled
//   clr_sticky          synchronous clear of sat_sticky (a coinciding saturating transfer wins)
//   sat_sticky          OR of ovfl over transferred results
module simd_addsat_pipe #(
    parameter int WIDTH = 16,
    parameter int LANES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovfl,
    input  logic             clr_sticky,
    output logic             sat_sticky
);
    localparam int LW = WIDTH / LANES;
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    if (WIDTH % LANES != 0 || LW < 2 || WIDTH < LW + $clog2(2*LANES)) begin : g_bad
        $error("simd_addsat_pipe: illegal WIDTH/LANES combination");
    end

    logic [WIDTH-1:0] bo, padds, acc;
    logic [WIDTH:0]   full;
    logic [LW:0]      ls;
    logic             fovf, povf;
    logic [WIDTH+1:0] r_res, s1_res_d, s1_res_q, s2_res_d, s2_res_q;
    logic             s1_full_d, s1_full_q, s2_full_d, s2_full_q, sticky_d, sticky_q;
    logic             s2_mv, acc_in;

    always_comb begin
        bo   = mode[0] ? ~b : b;
        full = {1'b0, a} + {1'b0, bo} + {{WIDTH{1'b0}}, mode[0]};
        fovf = (a[WIDTH-1] == bo[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
        padds = '0;
        povf  = 1'b0;
        acc   = '0;
        ls    = '0;
        for (int i = 0; i < LANES; i++) begin
            ls = {a[i*LW+LW-1], a[i*LW +: LW]} + {b[i*LW+LW-1], b[i*LW +: LW]};
            // lane overflow when the extra sign bit disagrees with the lane MSB
            padds[i*LW +: LW] = (ls[LW] != ls[LW-1]) ? {ls[LW], {(LW-1){~ls[LW]}}} : ls[LW-1:0];
            povf = povf | (ls[LW] != ls[LW-1]);
            acc = acc + {{(WIDTH-LW){a[i*LW+LW-1]}}, a[i*LW +: LW]}
                      + {{(WIDTH-LW){b[i*LW+LW-1]}}, b[i*LW +: LW]};
        end
        r_res[WIDTH-1:0] = mode == 2'b11 ? acc :
                           mode == 2'b10 ? padds :
                           fovf ? (a[WIDTH-1] ? SMIN : ~SMIN) : full[WIDTH-1:0];
        r_res[WIDTH]     = !mode[1] && full[WIDTH];
        r_res[WIDTH+1]   = mode == 2'b10 ? povf : (!mode[1] && fovf);
    end

    // S2 can load whenever it is empty or its result leaves this cycle
    assign s2_mv    = !s2_full_q || out_ready;
    assign in_ready = !s1_full_q || s2_mv;
    assign acc_in   = in_valid && in_ready;

    always_comb begin
        s1_full_d = acc_in || (s1_full_q && !s2_mv);
        s1_res_d  = acc_in ? r_res : s1_res_q;
        s2_full_d = s2_mv ? s1_full_q : s2_full_q;
        s2_res_d  = (s2_mv && s1_full_q) ? s1_res_q : s2_res_q;
        sticky_d  = (s2_full_q && out_ready && s2_res_q[WIDTH+1]) || (sticky_q && !clr_sticky);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_full_q <= 1'b0;
            s2_full_q <= 1'b0;
            s1_res_q  <= '0;
            s2_res_q  <= '0;
            sticky_q  <= 1'b0;
        end else begin
            s1_full_q <= s1_full_d;
            s2_full_q <= s2_full_d;
            s1_res_q  <= s1_res_d;
            s2_res_q  <= s2_res_d;
            sticky_q  <= sticky_d;
        end
    end

    assign out_valid         = s2_full_q;
    assign {ovfl, cout, sum} = s2_res_q;
    assign sat_sticky        = sticky_q;
endmodule

// File: doc/simd_addsat_pipe.md
SIMD_ADDSAT_PIPE -- requirements
Module: simd_addsat_pipe

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, datapath width in bits.
REQ-002 SHALL provide parameter LANES, default 4, lane count for PADDS/RED. LANE_W = WIDTH/LANES.
REQ-003 SHALL reject elaboration unless WIDTH%LANES==0, LANE_W>=2 and WIDTH >= LANE_W+clog2(2*LANES).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  operand set presented.
REQ-007 in_ready  output  1  block can accept an operand set this cycle.
REQ-008 a  input  WIDTH  first operand.
REQ-009 b  input  WIDTH  second operand.
REQ-010 mode  input  2  operation select: 00 ADD, 01 SUB, 10 PADDS, 11 RED.
REQ-011 out_valid  output  1  result held on outputs.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  unsigned carry-out (ADD/SUB only).
REQ-015 ovfl  output  1  saturation applied to this result.
REQ-016 clr_sticky  input  1  synchronous clear of sat_sticky.
REQ-017 sat_sticky  output  1  OR of ovfl over all results transferred since reset or clear.

Function
REQ-018 An input transfer SHALL occur when in_valid && in_ready; an output transfer when out_valid && out_ready.
REQ-019 The datapath SHALL be two registered stages (S1, S2). Latency is 2 cycles from input transfer to out_valid when the pipe is empty and out_ready=1. Sustained throughput is 1 per cycle.
REQ-020 in_ready SHALL equal !S1_full || !S2_full || out_ready. It SHALL be combinational only in out_ready, with no in_valid path.
REQ-021 Results SHALL leave in acceptance order. No transfer is dropped or duplicated.
REQ-022 While out_valid && !out_ready, sum, cout and ovfl SHALL hold stable.
REQ-023 ADD SHALL compute a+b as signed, saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-024 ADD: cout SHALL be bit WIDTH of the unsaturated unsigned sum.
REQ-025 SUB SHALL compute a+~b+1 with the same saturation as ADD. cout=1 means no borrow.
REQ-026 PADDS SHALL add each LANE_W-bit lane independently as signed, saturating per lane. No carry crosses lanes, and cout=0.
REQ-027 RED SHALL output the signed sum of all 2*LANES signed lanes of a and b, sign-extended to WIDTH.
REQ-028 RED SHALL apply no saturation, and SHALL set cout=0 and ovfl=0.
REQ-029 ovfl SHALL be 1 iff saturation changed the result: ADD/SUB full-width overflow, or PADDS overflow in any lane.
REQ-030 sat_sticky SHALL set on an output transfer with ovfl=1.
REQ-031 clr_sticky SHALL clear sat_sticky on the next edge. When clr_sticky coincides with a saturating output transfer, set SHALL win.
REQ-032 mode, a and b SHALL be sampled only at input transfer. Later changes SHALL not affect in-flight results.

Reset
REQ-033 While rst=1, outputs SHALL be: out_valid=0, sum=0, cout=0, ovfl=0, sat_sticky=0. in_ready=1 once rst deasserts.
REQ-034 Asserting rst mid-operation SHALL discard all in-flight results immediately, without waiting for a clock edge.
REQ-035 The first transfer after reset deassertion SHALL behave as from an empty pipe.

Verification (WIDTH=16, LANES=4)
REQ-036 ADD a=0x7FFF b=0x0001, out_ready=1 -> 2 cycles later out_valid=1, sum=0x7FFF, ovfl=1, cout=0, then sat_sticky=1.
REQ-037 SUB a=0x0005 b=0x0007 -> sum=0xFFFE, cout=0, ovfl=0. SUB a=0x8000 b=0x0001 -> sum=0x8000, ovfl=1, cout=1.
REQ-038 PADDS a=0x7788 b=0x1111 -> sum=0x7799, ovfl=1, cout=0.
REQ-039 RED a=0x1234 b=0xFFFF -> sum=0x0006, ovfl=0. RED a=0x8888 b=0x8888 -> sum=0xFFC0.
REQ-040 Backpressure: out_ready=0, offer 3 back-to-back ops -> 2 accepted, in_ready=0, outputs stable; raise out_ready -> results emerge in order, third accepted same cycle.
REQ-041 Reset mid-op: 2 ops in flight, pulse rst between edges -> out_valid=0 immediately, no stale result afterwards, sat_sticky=0.
